// File: rtl/sort_out_serializer.sv
// Group queue behind the 4-element sorter, streamed one element per val/rdy transfer (in0 first).
// Latency: group enqueued at edge t is presented in cycle t+1; out_* are comb from registered state.
// Backpressure: out_rdy=0 holds the element; a full queue drops the group (sticky overflow). Option: SORT_OUT_SERIALIZER_ORDER_CHECK_EN.
module sort_out_serializer #(
  parameter int p_nbits = 1,
  parameter int p_depth = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  input  logic [p_nbits-1:0]           in0,
  input  logic [p_nbits-1:0]           in1,
  input  logic [p_nbits-1:0]           in2,
  input  logic [p_nbits-1:0]           in3,
  output logic [$clog2(p_depth+1)-1:0] in_space,
  output logic                         overflow,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [p_nbits-1:0]           out_msg,
  output logic                         out_last,
  output logic                         order_err
);

  localparam int c_pw = $clog2(p_depth);
  localparam int c_cw = $clog2(p_depth + 1);
  localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);
  localparam logic [c_cw-1:0] c_depth   = c_cw'(p_depth);

  typedef logic [3:0][p_nbits-1:0] group_t;

  group_t          mem [p_depth];
  logic [c_pw-1:0] wr_ptr;
  logic [c_pw-1:0] rd_ptr;
  logic [c_cw-1:0] count;
  logic [c_cw-1:0] count_next;
  logic [c_cw-1:0] in_space_r;
  logic [1:0]      idx;
  logic            overflow_r;

  logic full;
  logic push;
  logic xfer;
  logic pop;

  // Full is judged on the registered count: a same-cycle pop never frees a slot.
  always_comb begin
    full       = (count == c_depth);
    push       = in_val && !full;
    xfer       = (count != '0) && out_rdy;
    pop        = xfer && (idx == 2'd3);
    count_next = count + c_cw'(push) - c_cw'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      in_space_r <= c_depth;
      overflow_r <= 1'b0;
      for (int i = 0; i < p_depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in3, in2, in1, in0};
        wr_ptr      <= wr_ptr + c_ptr_one;
      end
      if (in_val && full) begin
        overflow_r <= 1'b1;
      end
      if (xfer) begin
        idx <= idx + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + c_ptr_one;
      end
      count      <= count_next;
      in_space_r <= c_depth - count_next;
    end
  end

  always_comb begin
    out_val  = (count != '0);
    out_msg  = mem[rd_ptr][idx];
    out_last = out_val && (idx == 2'd3);
  end

  assign in_space = in_space_r;
  assign overflow = overflow_r;

`ifdef SORT_OUT_SERIALIZER_ORDER_CHECK_EN
  logic order_bad;
  logic order_err_r;

  // Only groups that actually enter the queue are checked.
  assign order_bad = (in0 > in1) || (in1 > in2) || (in2 > in3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      order_err_r <= 1'b0;
    end else if (push && order_bad) begin
      order_err_r <= 1'b1;
    end
  end

  assign order_err = order_err_r;
`else
  assign order_err = 1'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!$isunknown(in_val)) else $error("in_val is X");
      assert (!$isunknown(out_rdy)) else $error("out_rdy is X");
      assert (count <= c_depth) else $error("count exceeds depth");
    end
  end

  function automatic string line_trace();
    string s_out;
    if (out_val && out_rdy) begin
      s_out = $sformatf("%h", out_msg);
    end else if (out_val) begin
      s_out = "#";
    end else begin
      s_out = ".";
    end
    return $sformatf("%0d|q:%0d %0d|%s", in_space, count, idx, s_out);
  endfunction
`endif

endmodule

// File: tb/tb_sort_out_serializer.sv
// Bench for sort_out_serializer: directed cases then random traffic against a group-queue reference model.
module tb_sort_out_serializer;

  localparam int NB  = 4;
  localparam int DEP = 2;
  localparam int SW  = $clog2(DEP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val;
  logic [NB-1:0] in0, in1, in2, in3;
  logic [SW-1:0] in_space;
  logic          overflow;
  logic          out_val;
  logic          out_rdy;
  logic [NB-1:0] out_msg;
  logic          out_last;
  logic          order_err;

  always #5 clk = ~clk;

  sort_out_serializer #(.p_nbits(NB), .p_depth(DEP)) dut (
    .clk(clk), .reset(reset), .in_val(in_val),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in_space(in_space), .overflow(overflow),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_last(out_last), .order_err(order_err)
  );

  // Reference model: whole groups in a queue plus the position within the head group.
  logic [4*NB-1:0] gq[$];
  int pos;
  bit m_ovf;
  bit m_oerr;
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [4*NB-1:0] mk(int a, int b, int c, int d);
    logic [NB-1:0] ea, eb, ec, ed;
    ea = NB'(a); eb = NB'(b); ec = NB'(c); ed = NB'(d);
    return {ed, ec, eb, ea};
  endfunction

  function automatic bit ascending(logic [4*NB-1:0] g);
    for (int k = 0; k < 3; k++) begin
      if (g[k*NB +: NB] > g[(k+1)*NB +: NB]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(bit after_reset);
    bit              ev;
    logic [4*NB-1:0] head;
    logic [NB-1:0]   em;
    ev = (gq.size() != 0);
    chk("out_val", 32'(out_val), 32'(ev));
    chk("in_space", 32'(in_space), 32'(DEP - gq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("order_err", 32'(order_err), 32'(m_oerr));
    chk("out_last", 32'(out_last), 32'(ev && pos == 3));
    if (ev) begin
      head = gq[0];
      em   = head[pos*NB +: NB];
      chk("out_msg", 32'(out_msg), 32'(em));
    end else if (after_reset) begin
      chk("out_msg_rst", 32'(out_msg), 32'd0);
    end
  endtask

  task automatic cycle(bit v, logic [4*NB-1:0] g, bit r, bit after_reset = 1'b0);
    bit full;
    @(negedge clk);
    check_outputs(after_reset);
    reset = 1'b1;
    in_val = v;
    {in3, in2, in1, in0} = g;
    out_rdy = r;
    @(posedge clk);
    full = (gq.size() == DEP);
    if (gq.size() != 0 && r) begin
      if (pos == 3) begin
        void'(gq.pop_front());
        pos = 0;
      end else begin
        pos++;
      end
    end
    if (v) begin
      if (full) begin
        m_ovf = 1'b1;
      end else begin
        gq.push_back(g);
`ifdef SORT_OUT_SERIALIZER_ORDER_CHECK_EN
        if (!ascending(g)) m_oerr = 1'b1;
`endif
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_val = 1'b0;
    out_rdy = 1'b0;
    @(posedge clk);
    gq.delete();
    pos = 0;
    m_ovf = 1'b0;
    m_oerr = 1'b0;
  endtask

  task automatic drain(int n);
    repeat (n) cycle(1'b0, '0, 1'b1);
  endtask

  function automatic logic [4*NB-1:0] rand_group();
    int v0, v1, v2, v3;
    if ($urandom_range(0, 1) == 0) begin
      v0 = $urandom_range(0, 3);
      v1 = v0 + $urandom_range(0, 4);
      v2 = v1 + $urandom_range(0, 4);
      v3 = v2 + $urandom_range(0, 3);
      return mk(v0, v1, v2, v3);
    end
    return mk($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15));
  endfunction

  initial begin
    reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    gq.delete(); pos = 0; m_ovf = 1'b0; m_oerr = 1'b0;
    repeat (2) @(posedge clk);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // single group, always ready
    cycle(1'b1, mk(1, 2, 3, 4), 1'b1);
    drain(5);

    // stalls hold the current element
    cycle(1'b1, mk(7, 8, 9, 10), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    drain(4);

    // third back-to-back group is dropped
    cycle(1'b1, mk(1, 1, 2, 2), 1'b0);
    cycle(1'b1, mk(3, 4, 5, 6), 1'b0);
    cycle(1'b1, mk(9, 9, 9, 9), 1'b0);
    cycle(1'b0, '0, 1'b0);
    drain(10);

    // a group every 4 cycles: enqueue and pop share an edge
    for (int gi = 0; gi < 4; gi++) begin
      cycle(1'b1, mk(gi, gi + 1, gi + 2, gi + 3), 1'b1);
      drain(3);
    end
    drain(5);

    // reset mid-drain
    cycle(1'b1, mk(2, 4, 6, 8), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, mk(11, 12, 13, 14), 1'b1);
    drain(5);

    // non-ascending group still streams unchanged
    cycle(1'b1, mk(5, 3, 7, 9), 1'b1);
    drain(5);

    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
      end else begin
        cycle($urandom_range(0, 2) == 0, rand_group(), $urandom_range(0, 3) != 0);
      end
    end
    drain(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
